pipeline_ctrl: RTL

Central pipeline controller. It turns stage stall requests and the MEM-stage exception word into the `stall[5:0]` / `flush` / `new_pc` controls consumed by every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb). Exception entry is a two-cycle freeze-then-flush sequence, so `flush` and `new_pc` leave the block registered. It also keeps stall/flush statistics and a stall watchdog.

---
 rtl/pipeline_ctrl_if.sv | 24 ++
 rtl/pipeline_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline controller and the pipeline registers.
// The controller takes the master modport; the pipeline (or a bench) takes the slave modport.
interface pipeline_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic        wdog_o;

    modport master (
        input  stallreq_id, stallreq_ex, excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, stall_cycles, flush_count, wdog_o
    );

    modport slave (
        output stallreq_id, stallreq_ex, excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, stall_cycles, flush_count, wdog_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: stall decode, two-cycle freeze-then-flush exception entry,
// stall/flush statistics and a consecutive-stall watchdog.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    pipeline_ctrl_if.master   bus
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [31:0] ERET_CODE = 32'h0000_000e;
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_LIMIT - 32'd1);

    state_t      state_r;
    logic        flush_r;
    logic [31:0] new_pc_r;
    logic [31:0] stall_cycles_r;
    logic [15:0] flush_count_r;
    logic [15:0] run_cnt_r;
    logic        wdog_r;

    logic [5:0]  stall_s;
    logic        exc_s;
    logic        req_stall_s;

    // Stall decode; only RUN looks at the requests and the exception word.
    always_comb begin
        stall_s     = 6'b000000;
        exc_s       = 1'b0;
        req_stall_s = 1'b0;
        if (state_r == RUN) begin
            if (bus.excepttype_i != 32'h0000_0000) begin
                stall_s = 6'b111111;
                exc_s   = 1'b1;
            end else if (bus.stallreq_ex) begin
                stall_s     = 6'b001111;
                req_stall_s = 1'b1;
            end else if (bus.stallreq_id) begin
                stall_s     = 6'b000111;
                req_stall_s = 1'b1;
            end else begin
                stall_s = 6'b000000;
            end
        end else begin
            stall_s = 6'b000000;
        end
    end

    // Exception entry FSM; flush_count steps together with the flush pulse it counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RUN;
            flush_r       <= 1'b0;
            new_pc_r      <= 32'h0000_0000;
            flush_count_r <= 16'h0000;
        end else begin
            case (state_r)
                RUN: begin
                    if (exc_s) begin
                        state_r       <= FLUSH;
                        flush_r       <= 1'b1;
                        flush_count_r <= flush_count_r + 16'h0001;
                        new_pc_r      <= (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
                    end else begin
                        state_r <= RUN;
                        flush_r <= 1'b0;
                    end
                end
                FLUSH: begin
                    state_r <= RUN;
                    flush_r <= 1'b0;
                end
                default: begin
                    state_r <= RUN;
                    flush_r <= 1'b0;
                end
            endcase
        end
    end

    // Statistics and watchdog; freeze and FLUSH cycles break a stall run.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= 32'h0000_0000;
            run_cnt_r      <= 16'h0000;
            wdog_r         <= 1'b0;
        end else begin
            if (req_stall_s) begin
                if (stall_cycles_r != 32'hFFFF_FFFF) begin
                    stall_cycles_r <= stall_cycles_r + 32'h0000_0001;
                end else begin
                    stall_cycles_r <= stall_cycles_r;
                end
                if (run_cnt_r != 16'hFFFF) begin
                    run_cnt_r <= run_cnt_r + 16'h0001;
                end else begin
                    run_cnt_r <= run_cnt_r;
                end
                if (run_cnt_r == WDOG_LAST) begin
                    wdog_r <= 1'b1;
                end else begin
                    wdog_r <= wdog_r;
                end
            end else begin
                run_cnt_r <= 16'h0000;
            end
        end
    end

    assign bus.stall        = stall_s;
    assign bus.flush        = flush_r;
    assign bus.new_pc       = new_pc_r;
    assign bus.stall_cycles = stall_cycles_r;
    assign bus.flush_count  = flush_count_r;
    assign bus.wdog_o       = wdog_r;

endmodule
